dmi_arbiter: RTL and testbench

//  Shares one debug module interface (DMI) request/response port between two

---
 rtl/dmi_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_dmi_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_arbiter.sv
// Two-requester round-robin front end for a single DMI port: one transaction in
// flight, responses routed back to the issuing requester, watchdog on hung targets.
module dmi_arbiter #(
  parameter int ADDR_W         = 7,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              s0_req_valid,
  output logic              s0_req_ready,
  input  logic [ADDR_W-1:0] s0_req_addr,
  input  logic [1:0]        s0_req_op,
  input  logic [DATA_W-1:0] s0_req_data,
  output logic              s0_resp_valid,
  input  logic              s0_resp_ready,
  output logic [1:0]        s0_resp_resp,
  output logic [DATA_W-1:0] s0_resp_data,

  input  logic              s1_req_valid,
  output logic              s1_req_ready,
  input  logic [ADDR_W-1:0] s1_req_addr,
  input  logic [1:0]        s1_req_op,
  input  logic [DATA_W-1:0] s1_req_data,
  output logic              s1_resp_valid,
  input  logic              s1_resp_ready,
  output logic [1:0]        s1_resp_resp,
  output logic [DATA_W-1:0] s1_resp_data,

  output logic              m_req_valid,
  input  logic              m_req_ready,
  output logic [ADDR_W-1:0] m_req_addr,
  output logic [1:0]        m_req_op,
  output logic [DATA_W-1:0] m_req_data,
  input  logic              m_resp_valid,
  output logic              m_resp_ready,
  input  logic [1:0]        m_resp_resp,
  input  logic [DATA_W-1:0] m_resp_data,

  output logic              busy,
  output logic              timeout
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_DELIVER = 2'd3;

  localparam int                WDOG_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);
  localparam bit                WDOG_EN   = (TIMEOUT_CYCLES != 0);

  localparam logic [1:0] RESP_FAILED = 2'b10;

  // Per-requester views of the port pairs so the arbitration logic is indexable.
  logic [1:0]        req_valid_w;
  logic [1:0]        resp_ready_w;
  logic [1:0]        req_ready_w;
  logic [1:0]        resp_valid_w;
  logic [ADDR_W-1:0] req_addr_w [2];
  logic [1:0]        req_op_w   [2];
  logic [DATA_W-1:0] req_data_w [2];

  assign req_valid_w   = {s1_req_valid, s0_req_valid};
  assign resp_ready_w  = {s1_resp_ready, s0_resp_ready};
  assign req_addr_w[0] = s0_req_addr;
  assign req_addr_w[1] = s1_req_addr;
  assign req_op_w[0]   = s0_req_op;
  assign req_op_w[1]   = s1_req_op;
  assign req_data_w[0] = s0_req_data;
  assign req_data_w[1] = s1_req_data;

  logic [1:0]        state_reg,     state_next;
  logic              owner_reg,     owner_next;
  logic              last_reg,      last_next;
  logic              stale_reg,     stale_next;
  logic [WDOG_W-1:0] wdog_reg,      wdog_next;
  logic [ADDR_W-1:0] req_addr_reg,  req_addr_next;
  logic [1:0]        req_op_reg,    req_op_next;
  logic [DATA_W-1:0] req_data_reg,  req_data_next;
  logic [1:0]        resp_resp_reg, resp_resp_next;
  logic [DATA_W-1:0] resp_data_reg, resp_data_next;

  logic grant_ok;
  logic winner;
  logic in_flight;
  logic wdog_fire;
  logic resp_take;

  // A stale response still owed by the debug module blocks new grants.
  assign grant_ok  = (state_reg == ST_IDLE) && !stale_reg && !reset && (req_valid_w != 2'b00);
  assign winner    = (req_valid_w == 2'b11) ? ~last_reg : req_valid_w[1];
  assign in_flight = (state_reg == ST_REQ) || (state_reg == ST_WAIT);
  assign wdog_fire = WDOG_EN && in_flight && (wdog_reg == WDOG_LAST);
  assign resp_take = (state_reg == ST_WAIT) && m_resp_valid;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign req_ready_w[gi]  = grant_ok && (winner == 1'(gi));
      assign resp_valid_w[gi] = (state_reg == ST_DELIVER) && (owner_reg == 1'(gi));
    end
  endgenerate

  assign s0_req_ready  = req_ready_w[0];
  assign s1_req_ready  = req_ready_w[1];
  assign s0_resp_valid = resp_valid_w[0];
  assign s1_resp_valid = resp_valid_w[1];
  assign s0_resp_resp  = resp_resp_reg;
  assign s1_resp_resp  = resp_resp_reg;
  assign s0_resp_data  = resp_data_reg;
  assign s1_resp_data  = resp_data_reg;

  // The request is withdrawn in the very cycle the watchdog aborts it.
  assign m_req_valid  = (state_reg == ST_REQ) && !wdog_fire;
  assign m_req_addr   = req_addr_reg;
  assign m_req_op     = req_op_reg;
  assign m_req_data   = req_data_reg;
  assign m_resp_ready = (state_reg == ST_WAIT) || stale_reg;

  assign busy    = (state_reg != ST_IDLE) || stale_reg;
  assign timeout = wdog_fire && !resp_take;

  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    last_next      = last_reg;
    stale_next     = stale_reg;
    wdog_next      = in_flight ? (wdog_reg + WDOG_W'(1)) : wdog_reg;
    req_addr_next  = req_addr_reg;
    req_op_next    = req_op_reg;
    req_data_next  = req_data_reg;
    resp_resp_next = resp_resp_reg;
    resp_data_next = resp_data_reg;

    if (stale_reg && m_resp_valid) begin
      stale_next = 1'b0;
    end

    case (state_reg)
      ST_IDLE: begin
        if (grant_ok) begin
          owner_next    = winner;
          req_addr_next = req_addr_w[winner];
          req_op_next   = req_op_w[winner];
          req_data_next = req_data_w[winner];
          wdog_next     = '0;
          state_next    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (wdog_fire) begin
          resp_resp_next = RESP_FAILED;
          resp_data_next = '0;
          state_next     = ST_DELIVER;
        end else if (m_req_ready) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A response landing together with the timeout wins over the abort.
        if (m_resp_valid) begin
          resp_resp_next = m_resp_resp;
          resp_data_next = m_resp_data;
          state_next     = ST_DELIVER;
        end else if (wdog_fire) begin
          resp_resp_next = RESP_FAILED;
          resp_data_next = '0;
          stale_next     = 1'b1;
          state_next     = ST_DELIVER;
        end
      end
      ST_DELIVER: begin
        if (resp_ready_w[owner_reg]) begin
          last_next  = owner_reg;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      owner_reg     <= 1'b0;
      last_reg      <= 1'b1;
      stale_reg     <= 1'b0;
      wdog_reg      <= '0;
      req_addr_reg  <= '0;
      req_op_reg    <= '0;
      req_data_reg  <= '0;
      resp_resp_reg <= '0;
      resp_data_reg <= '0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      last_reg      <= last_next;
      stale_reg     <= stale_next;
      wdog_reg      <= wdog_next;
      req_addr_reg  <= req_addr_next;
      req_op_reg    <= req_op_next;
      req_data_reg  <= req_data_next;
      resp_resp_reg <= resp_resp_next;
      resp_data_reg <= resp_data_next;
    end
  end

endmodule

// File: tb/tb_dmi_arbiter.sv
// Bench for dmi_arbiter: table of transactions plus hand-written reset and stale sequences.
module tb_dmi_arbiter;

  localparam int AW = 7;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          s0_req_valid, s0_req_ready, s0_resp_valid, s0_resp_ready;
  logic [AW-1:0] s0_req_addr;
  logic [1:0]    s0_req_op, s0_resp_resp;
  logic [DW-1:0] s0_req_data, s0_resp_data;
  logic          s1_req_valid, s1_req_ready, s1_resp_valid, s1_resp_ready;
  logic [AW-1:0] s1_req_addr;
  logic [1:0]    s1_req_op, s1_resp_resp;
  logic [DW-1:0] s1_req_data, s1_resp_data;
  logic          m_req_valid, m_req_ready, m_resp_valid, m_resp_ready;
  logic [AW-1:0] m_req_addr;
  logic [1:0]    m_req_op, m_resp_resp;
  logic [DW-1:0] m_req_data, m_resp_data;
  logic          busy, timeout;

  dmi_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .s0_req_valid(s0_req_valid), .s0_req_ready(s0_req_ready), .s0_req_addr(s0_req_addr),
    .s0_req_op(s0_req_op), .s0_req_data(s0_req_data), .s0_resp_valid(s0_resp_valid),
    .s0_resp_ready(s0_resp_ready), .s0_resp_resp(s0_resp_resp), .s0_resp_data(s0_resp_data),
    .s1_req_valid(s1_req_valid), .s1_req_ready(s1_req_ready), .s1_req_addr(s1_req_addr),
    .s1_req_op(s1_req_op), .s1_req_data(s1_req_data), .s1_resp_valid(s1_resp_valid),
    .s1_resp_ready(s1_resp_ready), .s1_resp_resp(s1_resp_resp), .s1_resp_data(s1_resp_data),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
    .m_req_op(m_req_op), .m_req_data(m_req_data), .m_resp_valid(m_resp_valid),
    .m_resp_ready(m_resp_ready), .m_resp_resp(m_resp_resp), .m_resp_data(m_resp_data),
    .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // exp_to: 0 no timeout pulse, 1 pulse on the TO-th REQ/WAIT cycle, 2 not checked.
  typedef struct {
    bit          v0, v1;
    logic [6:0]  a0, a1;
    logic [1:0]  op0, op1;
    logic [31:0] d0, d1;
    int          req_wait, resp_wait;
    logic [1:0]  dm_resp;
    logic [31:0] dm_data;
    int          sresp_wait;
    int          exp_port;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
    int          exp_to;
    bit          exp_stale;
  } vec_t;

  typedef struct {
    int          port;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  vec_t vecs [10];
  exp_t sb [$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   n_txn  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    s0_req_valid = 1'b0; s0_req_addr = '0; s0_req_op = '0; s0_req_data = '0; s0_resp_ready = 1'b0;
    s1_req_valid = 1'b0; s1_req_addr = '0; s1_req_op = '0; s1_req_data = '0; s1_resp_ready = 1'b0;
    m_req_ready = 1'b0; m_resp_valid = 1'b0; m_resp_resp = '0; m_resp_data = '0;
  endtask

  task automatic check_all_quiet(input string tag);
    check({tag, "_req_ready"}, {30'b0, s1_req_ready, s0_req_ready}, 32'd0);
    check({tag, "_resp_valid"}, {30'b0, s1_resp_valid, s0_resp_valid}, 32'd0);
    check({tag, "_m_req_valid"}, m_req_valid, 32'd0);
    check({tag, "_m_resp_ready"}, m_resp_ready, 32'd0);
    check({tag, "_busy"}, busy, 32'd0);
    check({tag, "_timeout"}, timeout, 32'd0);
    check({tag, "_m_req_addr"}, m_req_addr, 32'd0);
  endtask

  task automatic run_vector(input vec_t v);
    int          gp, rw, to_at;
    bit          acc, done;
    exp_t        e;
    logic [6:0]  ea;
    logic [1:0]  eo;
    logic [31:0] ed;
    gp = -1; rw = 0; to_at = 0; acc = 1'b0; done = 1'b0;

    for (int c = 0; c < 4 && gp < 0; c++) begin
      @(negedge clk); drive_idle();
      s0_req_valid = v.v0; s0_req_addr = v.a0; s0_req_op = v.op0; s0_req_data = v.d0;
      s1_req_valid = v.v1; s1_req_addr = v.a1; s1_req_op = v.op1; s1_req_data = v.d1;
      #2;
      check("dual_ready", {31'b0, s0_req_ready & s1_req_ready}, 32'd0);
      check("m_req_valid_in_idle", m_req_valid, 32'd0);
      if (s0_req_ready) gp = 0;
      else if (s1_req_ready) gp = 1;
    end
    check("grant_port", gp, v.exp_port);
    if (gp < 0) return;

    e.port = gp; e.resp = v.exp_resp; e.data = v.exp_data;
    sb.push_back(e);
    ea = (gp == 1) ? v.a1 : v.a0;
    eo = (gp == 1) ? v.op1 : v.op0;
    ed = (gp == 1) ? v.d1 : v.d0;

    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk); drive_idle();
      m_req_ready = (k >= v.req_wait);
      #2; rw++;
      if (timeout) begin
        to_at = rw;
        check("abort_drops_m_req_valid", m_req_valid, 32'd0);
        done = 1'b1;
      end else begin
        check("m_req_valid", m_req_valid, 32'd1);
        check("m_req_addr", m_req_addr, ea);
        check("m_req_op", m_req_op, eo);
        check("m_req_data", m_req_data, ed);
        if (m_req_ready) begin acc = 1'b1; done = 1'b1; end
      end
    end
    check("req_phase_bound", done, 32'd1);

    if (acc) begin
      done = 1'b0;
      for (int j = 0; j < 40 && !done; j++) begin
        @(negedge clk); drive_idle();
        m_resp_valid = (v.resp_wait >= 0) && (j >= v.resp_wait);
        m_resp_resp = v.dm_resp; m_resp_data = v.dm_data;
        #2; rw++;
        check("m_resp_ready_in_wait", m_resp_ready, 32'd1);
        check("m_req_valid_in_wait", m_req_valid, 32'd0);
        if (timeout) to_at = rw;
        if (timeout || m_resp_valid) done = 1'b1;
      end
      check("wait_phase_bound", done, 32'd1);
    end
    if (v.exp_to != 2) check("timeout_cycle", to_at, (v.exp_to == 1) ? TO : 0);

    e = sb.pop_front();
    for (int h = 0; h <= v.sresp_wait; h++) begin
      @(negedge clk); drive_idle();
      s0_req_valid = 1'b1; s1_req_valid = 1'b1;
      if (e.port == 0) s0_resp_ready = (h == v.sresp_wait);
      else             s1_resp_ready = (h == v.sresp_wait);
      #2;
      check("no_grant_in_deliver", {31'b0, s0_req_ready | s1_req_ready}, 32'd0);
      check("resp_valid_owner", (e.port == 1) ? s1_resp_valid : s0_resp_valid, 32'd1);
      check("resp_valid_other", (e.port == 1) ? s0_resp_valid : s1_resp_valid, 32'd0);
      check("resp_code", (e.port == 1) ? s1_resp_resp : s0_resp_resp, e.resp);
      check("resp_data", (e.port == 1) ? s1_resp_data : s0_resp_data, e.data);
    end
    n_txn++;
    $display("txn %0d: port %0d addr %h op %0d -> resp %0d data %h timeout_at %0d",
             n_txn, e.port, ea, eo, (e.port == 1) ? s1_resp_resp : s0_resp_resp,
             (e.port == 1) ? s1_resp_data : s0_resp_data, to_at);

    @(negedge clk); drive_idle(); #2;
    check("busy_after_txn", busy, v.exp_stale);
    check("resp_valid_after_txn", {30'b0, s1_resp_valid, s0_resp_valid}, 32'd0);

    if (v.exp_stale) begin
      @(negedge clk); drive_idle();
      s0_req_valid = 1'b1; s1_req_valid = 1'b1;
      m_resp_valid = 1'b1; m_resp_data = 32'h0BAD0BAD;
      #2;
      check("stale_blocks_grant", {30'b0, s1_req_ready, s0_req_ready}, 32'd0);
      check("stale_resp_ready", m_resp_ready, 32'd1);
      @(negedge clk); drive_idle(); #2;
      check("stale_cleared", busy, 32'd0);
      check("late_resp_swallowed", {30'b0, s1_resp_valid, s0_resp_valid}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: got no finish, expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    //           v0    v1    a0     a1     op0   op1   d0            d1            rqw rsw dm_r  dm_data       srw port e_r   e_data        to stale
    vecs[0] = '{1'b1, 1'b1, 7'h11, 7'h12, 2'd1, 2'd2, 32'h0,        32'h11110000, 0,  0,  2'd0, 32'hDEADBEEF, 0,  0,  2'd0, 32'hDEADBEEF, 0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 7'h20, 7'h21, 2'd2, 2'd1, 32'h12345678, 32'h0,        0,  1,  2'd0, 32'hCAFEF00D, 0,  1,  2'd0, 32'hCAFEF00D, 0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 7'h30, 7'h31, 2'd1, 2'd1, 32'h0,        32'h0,        1,  2,  2'd3, 32'h0,        1,  0,  2'd3, 32'h0,        0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 7'h40, 7'h41, 2'd1, 2'd2, 32'h0,        32'hA5A55A5A, 5,  0,  2'd0, 32'h600DF00D, 3,  1,  2'd0, 32'h600DF00D, 0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 7'h7F, 7'h00, 2'd0, 2'd0, 32'hFFFFFFFF, 32'h0,        0,  0,  2'd0, 32'h00000077, 0,  0,  2'd0, 32'h00000077, 0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 7'h00, 7'h55, 2'd0, 2'd1, 32'h0,        32'h0,        0,  -1, 2'd0, 32'h0,        0,  1,  2'd2, 32'h0,        1, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 7'h66, 7'h00, 2'd2, 2'd0, 32'h0BADC0DE, 32'h0,        100, 0, 2'd0, 32'h00012345, 0,  0,  2'd2, 32'h0,        1, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 7'h10, 7'h11, 2'd1, 2'd1, 32'h0,        32'h0,        0,  2,  2'd2, 32'h00000001, 2,  1,  2'd2, 32'h00000001, 0, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 7'h08, 7'h09, 2'd2, 2'd2, 32'h8,        32'h9,        0,  6,  2'd0, 32'h0000BEEF, 0,  0,  2'd0, 32'h0000BEEF, 2, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 7'h00, 7'h3C, 2'd0, 2'd1, 32'h0,        32'h0,        0,  5,  2'd0, 32'h00005555, 0,  1,  2'd0, 32'h00005555, 0, 1'b0};

    drive_idle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); drive_idle();
      s0_req_valid = 1'b1; s1_req_valid = 1'b1;
      #2;
      check_all_quiet("in_reset");
    end
    @(negedge clk); drive_idle(); reset = 1'b0; #2;
    check_all_quiet("after_reset");

    foreach (vecs[i]) run_vector(vecs[i]);

    // Reset while the debug module owes a response.
    @(negedge clk); drive_idle();
    s0_req_valid = 1'b1; s0_req_addr = 7'h22; s0_req_op = 2'd1;
    #2; check("rst_seq_grant", s0_req_ready, 32'd1);
    @(negedge clk); drive_idle(); m_req_ready = 1'b1;
    #2; check("rst_seq_req", m_req_valid, 32'd1);
    @(negedge clk); drive_idle();
    #2; check("rst_seq_in_wait", m_resp_ready, 32'd1);
    @(negedge clk); drive_idle(); reset = 1'b1; #2;
    @(negedge clk); drive_idle(); reset = 1'b0; #2;
    check_all_quiet("reset_in_wait");
    run_vector(vecs[9]);

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
